// File: rtl/conv_layer_engine_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution engine family: the pass-sequencer
// state encoding, fixed-point rescale/saturate helpers and a width helper.
// Every arithmetic helper works on a 64-bit signed carrier. Callers
// sign-extend into it and truncate back out.
// ---------------------------------------------------------------------------
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } conv_state_e;

    localparam int FX_WIDE = 64;
    typedef logic signed [FX_WIDE-1:0] fx_wide_t;

    // Address/counter width that never collapses to zero bits
    function automatic int clog2_min1(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    // Drop the fractional bits; arithmetic shift gives floor for negatives
    function automatic fx_wide_t fx_rescale(input fx_wide_t v, input int frac);
        return v >>> frac;
    endfunction

    // Clamp to the signed range of a dw-bit word
    function automatic fx_wide_t fx_saturate(input fx_wide_t v, input int dw);
        fx_wide_t hi;
        fx_wide_t lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/conv_layer_engine_if.sv
// ---------------------------------------------------------------------------
// conv_layer_engine_if
// Groups every non-clock/reset signal of the convolution engine.
//   slave  : the engine side (drives RAM address, result, status)
//   master : the controller / RAM / next-layer side
// Signals: run, conv_data_addr/conv_data (input RAM), wt_wr_* (kernel
// load), bias_wr_* (bias load), result_rd_*/result (result read-back),
// channel_count, busy, done.
// ---------------------------------------------------------------------------
interface conv_layer_engine_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 12,
    parameter int IN_WIDTH    = 28,
    parameter int IN_HEIGHT   = 28,
    parameter int KERNEL_SIZE = 5,
    parameter int CHANNEL_NUM = 6
);
    localparam int KK      = KERNEL_SIZE * KERNEL_SIZE;
    localparam int OUT_PIX = (IN_WIDTH - KERNEL_SIZE + 1) * (IN_HEIGHT - KERNEL_SIZE + 1);
    localparam int WT_AW   = conv_pkg::clog2_min1(CHANNEL_NUM * KK);
    localparam int CH_W    = conv_pkg::clog2_min1(CHANNEL_NUM);
    localparam int RD_AW   = conv_pkg::clog2_min1(OUT_PIX);

    logic                          run;
    logic [ADDR_WIDTH-1:0]         conv_data_addr;
    logic signed [DATA_WIDTH-1:0]  conv_data;
    logic                          wt_wr_en;
    logic [WT_AW-1:0]              wt_wr_addr;
    logic signed [DATA_WIDTH-1:0]  wt_wr_data;
    logic                          bias_wr_en;
    logic [CH_W-1:0]               bias_wr_ch;
    logic signed [DATA_WIDTH-1:0]  bias_wr_data;
    logic [CH_W-1:0]               result_rd_ch;
    logic [RD_AW-1:0]              result_rd_addr;
    logic signed [DATA_WIDTH-1:0]  result;
    logic [CH_W-1:0]               channel_count;
    logic                          busy;
    logic                          done;

    modport slave (
        input  run, conv_data,
        input  wt_wr_en, wt_wr_addr, wt_wr_data,
        input  bias_wr_en, bias_wr_ch, bias_wr_data,
        input  result_rd_ch, result_rd_addr,
        output conv_data_addr, result, channel_count, busy, done
    );

    modport master (
        output run, conv_data,
        output wt_wr_en, wt_wr_addr, wt_wr_data,
        output bias_wr_en, bias_wr_ch, bias_wr_data,
        output result_rd_ch, result_rd_addr,
        input  conv_data_addr, result, channel_count, busy, done
    );

endinterface

// File: rtl/conv_layer_engine_mac.sv
// ---------------------------------------------------------------------------
// conv_mac_unit
// Signed multiply-accumulate with clear/enable, then bias add, rescale,
// saturation and (with CONV_RELU_EN defined) ReLU clamp of the result.
// Ports:
//   clk, reset   clock, async active-low reset (clears the accumulator)
//   clear        zero the accumulator (wins over en)
//   en           add data*weight into the accumulator
//   data, weight signed DATA_WIDTH operands
//   bias         signed DATA_WIDTH bias in the same fixed-point format
//   pixel        finished output word for the current accumulator value
// Optional feature macro: CONV_RELU_EN.
// ---------------------------------------------------------------------------
module conv_mac_unit
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int FRACTION_WIDTH = 8,
    parameter int ACC_WIDTH      = 37
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          en,
    input  logic signed [DATA_WIDTH-1:0]  data,
    input  logic signed [DATA_WIDTH-1:0]  weight,
    input  logic signed [DATA_WIDTH-1:0]  bias,
    output logic signed [DATA_WIDTH-1:0]  pixel
);
    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0]        prod_s;
    logic signed [ACC_WIDTH-1:0] acc_r;
    fx_wide_t                    sum_s;
    fx_wide_t                    sat_s;

    assign prod_s = PW'(data) * PW'(weight);

    // Accumulator: clear on the first tap slot, add one product per enable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_r <= {ACC_WIDTH{1'b0}};
        end else if (clear) begin
            acc_r <= {ACC_WIDTH{1'b0}};
        end else if (en) begin
            acc_r <= acc_r + ACC_WIDTH'(prod_s);
        end
    end

    // Output stage: bias aligned to the product's 2*FRACTION_WIDTH scale
    always_comb begin
        sum_s = FX_WIDE'(acc_r) + (FX_WIDE'(bias) <<< FRACTION_WIDTH);
        sat_s = fx_saturate(fx_rescale(sum_s, FRACTION_WIDTH), DATA_WIDTH);
`ifdef CONV_RELU_EN
        if (sat_s < 64'sd0) begin
            pixel = {DATA_WIDTH{1'b0}};
        end else begin
            pixel = DATA_WIDTH'(sat_s);
        end
`else
        pixel = DATA_WIDTH'(sat_s);
`endif
    end

endmodule

// File: rtl/conv_layer_engine.sv
// ---------------------------------------------------------------------------
// conv_layer_engine
// Multi-channel valid-padding 2-D convolution of one input map held in an
// external synchronous RAM. Kernels and biases live in runtime-loadable
// storage, and results go to an internal per-channel buffer. One MAC per
// cycle, so each output pixel takes KK+2 cycles (KK issue, drain, write).
// Ports:
//   clk    clock
//   reset  asynchronous active-low reset
//   bus    conv_layer_engine_if.slave (run, RAM port, kernel/bias load,
//          result read-back, channel_count, busy, done)
// Optional feature macro: CONV_RELU_EN (negative outputs written as zero).
// ---------------------------------------------------------------------------
module conv_layer_engine
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int FRACTION_WIDTH = 8,
    parameter int ADDR_WIDTH     = 12,
    parameter int IN_WIDTH       = 28,
    parameter int IN_HEIGHT      = 28,
    parameter int KERNEL_SIZE    = 5,
    parameter int CHANNEL_NUM    = 6
) (
    input  logic               clk,
    input  logic               reset,
    conv_layer_engine_if.slave bus
);
    localparam int OUT_WIDTH  = IN_WIDTH - KERNEL_SIZE + 1;
    localparam int OUT_HEIGHT = IN_HEIGHT - KERNEL_SIZE + 1;
    localparam int KK         = KERNEL_SIZE * KERNEL_SIZE;
    localparam int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(KK);
    localparam int OUT_PIX    = OUT_WIDTH * OUT_HEIGHT;
    localparam int WT_DEPTH   = CHANNEL_NUM * KK;
    localparam int RES_DEPTH  = CHANNEL_NUM * OUT_PIX;
    localparam int K_W        = clog2_min1(KERNEL_SIZE);
    localparam int ROW_W      = clog2_min1(OUT_HEIGHT);
    localparam int COL_W      = clog2_min1(OUT_WIDTH);
    localparam int CH_W       = clog2_min1(CHANNEL_NUM);
    localparam int WT_AW      = clog2_min1(WT_DEPTH);
    localparam int RES_AW     = clog2_min1(RES_DEPTH);

    logic signed [DATA_WIDTH-1:0] wt_mem   [WT_DEPTH];
    logic signed [DATA_WIDTH-1:0] bias_mem [CHANNEL_NUM];
    logic signed [DATA_WIDTH-1:0] res_mem  [RES_DEPTH];

    conv_state_e                  state_r;
    logic                         run_q_r;
    logic                         busy_r;
    logic                         done_r;
    logic [CH_W-1:0]              ch_r;
    logic [ROW_W-1:0]             row_r;
    logic [COL_W-1:0]             col_r;
    logic [K_W-1:0]               kr_r;
    logic [K_W-1:0]               kc_r;
    logic [ADDR_WIDTH-1:0]        addr_r;
    logic                         tap_valid_r;
    logic signed [DATA_WIDTH-1:0] wt_q_r;
    logic signed [DATA_WIDTH-1:0] result_r;

    logic [CH_W-1:0]              ch_n_s;
    logic [ROW_W-1:0]             row_n_s;
    logic [COL_W-1:0]             col_n_s;
    logic [K_W-1:0]               kr_n_s;
    logic [K_W-1:0]               kc_n_s;
    logic [ADDR_WIDTH-1:0]        addr_n_s;
    logic                         start_s;
    logic                         last_tap_s;
    logic                         last_pix_s;
    logic                         acc_clear_s;
    logic [WT_AW-1:0]             wt_rd_idx_s;
    logic [RES_AW-1:0]            res_wr_idx_s;
    logic [RES_AW-1:0]            res_rd_idx_s;
    logic signed [DATA_WIDTH-1:0] pixel_s;

    assign start_s     = bus.run & ~run_q_r;
    assign last_tap_s  = (kr_r == K_W'(KERNEL_SIZE - 1)) && (kc_r == K_W'(KERNEL_SIZE - 1));
    assign last_pix_s  = (row_r == ROW_W'(OUT_HEIGHT - 1)) && (col_r == COL_W'(OUT_WIDTH - 1)) &&
                         (ch_r == CH_W'(CHANNEL_NUM - 1));
    assign acc_clear_s = (state_r == ISSUE) && (kr_r == {K_W{1'b0}}) && (kc_r == {K_W{1'b0}});
    assign wt_rd_idx_s = WT_AW'(ch_r) * WT_AW'(KK) + WT_AW'(kr_r) * WT_AW'(KERNEL_SIZE) + WT_AW'(kc_r);
    assign res_wr_idx_s = RES_AW'(ch_r) * RES_AW'(OUT_PIX) + RES_AW'(row_r) * RES_AW'(OUT_WIDTH) +
                          RES_AW'(col_r);
    assign res_rd_idx_s = RES_AW'(bus.result_rd_ch) * RES_AW'(OUT_PIX) + RES_AW'(bus.result_rd_addr);

    // Next tap / pixel coordinates; the RAM address is registered from these
    // so it is already valid during the ISSUE cycle it belongs to
    always_comb begin
        ch_n_s  = ch_r;
        row_n_s = row_r;
        col_n_s = col_r;
        kr_n_s  = kr_r;
        kc_n_s  = kc_r;
        case (state_r)
            IDLE, DONE: begin
                if (start_s) begin
                    ch_n_s  = {CH_W{1'b0}};
                    row_n_s = {ROW_W{1'b0}};
                    col_n_s = {COL_W{1'b0}};
                    kr_n_s  = {K_W{1'b0}};
                    kc_n_s  = {K_W{1'b0}};
                end else begin
                    ch_n_s = ch_r;
                end
            end
            ISSUE: begin
                if (kc_r == K_W'(KERNEL_SIZE - 1)) begin
                    kc_n_s = {K_W{1'b0}};
                    if (kr_r == K_W'(KERNEL_SIZE - 1)) begin
                        kr_n_s = {K_W{1'b0}};
                    end else begin
                        kr_n_s = kr_r + K_W'(1'b1);
                    end
                end else begin
                    kc_n_s = kc_r + K_W'(1'b1);
                end
            end
            WRITE: begin
                if (col_r == COL_W'(OUT_WIDTH - 1)) begin
                    col_n_s = {COL_W{1'b0}};
                    if (row_r == ROW_W'(OUT_HEIGHT - 1)) begin
                        row_n_s = {ROW_W{1'b0}};
                        if (ch_r == CH_W'(CHANNEL_NUM - 1)) begin
                            ch_n_s = {CH_W{1'b0}};
                        end else begin
                            ch_n_s = ch_r + CH_W'(1'b1);
                        end
                    end else begin
                        row_n_s = row_r + ROW_W'(1'b1);
                    end
                end else begin
                    col_n_s = col_r + COL_W'(1'b1);
                end
            end
            default: begin
                ch_n_s = ch_r;
            end
        endcase
        addr_n_s = (ADDR_WIDTH'(row_n_s) + ADDR_WIDTH'(kr_n_s)) * ADDR_WIDTH'(IN_WIDTH) +
                   ADDR_WIDTH'(col_n_s) + ADDR_WIDTH'(kc_n_s);
    end

    // Pass sequencer with registered status outputs and RAM address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            run_q_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ch_r    <= {CH_W{1'b0}};
            row_r   <= {ROW_W{1'b0}};
            col_r   <= {COL_W{1'b0}};
            kr_r    <= {K_W{1'b0}};
            kc_r    <= {K_W{1'b0}};
            addr_r  <= {ADDR_WIDTH{1'b0}};
        end else begin
            run_q_r <= bus.run;
            ch_r    <= ch_n_s;
            row_r   <= row_n_s;
            col_r   <= col_n_s;
            kr_r    <= kr_n_s;
            kc_r    <= kc_n_s;
            case (state_r)
                IDLE, DONE: begin
                    if (start_s) begin
                        state_r <= ISSUE;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        addr_r  <= addr_n_s;
                    end
                end
                ISSUE: begin
                    if (last_tap_s) begin
                        state_r <= DRAIN;
                    end else begin
                        addr_r <= addr_n_s;
                    end
                end
                DRAIN: begin
                    state_r <= WRITE;
                end
                WRITE: begin
                    if (last_pix_s) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ISSUE;
                        addr_r  <= addr_n_s;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Kernel operand and accumulate-enable, one cycle behind ISSUE to meet RAM data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tap_valid_r <= 1'b0;
            wt_q_r      <= {DATA_WIDTH{1'b0}};
        end else begin
            tap_valid_r <= (state_r == ISSUE);
            if (state_r == ISSUE) begin
                wt_q_r <= wt_mem[wt_rd_idx_s];
            end
        end
    end

    // Kernel and bias storage: loads accepted only while no pass is running
    always_ff @(posedge clk) begin
        if (bus.wt_wr_en && !busy_r && (32'(bus.wt_wr_addr) < 32'(WT_DEPTH))) begin
            wt_mem[bus.wt_wr_addr] <= bus.wt_wr_data;
        end
        if (bus.bias_wr_en && !busy_r && (32'(bus.bias_wr_ch) < 32'(CHANNEL_NUM))) begin
            bias_mem[bus.bias_wr_ch] <= bus.bias_wr_data;
        end
    end

    // Result buffer write at the end of each WRITE cycle
    always_ff @(posedge clk) begin
        if (state_r == WRITE) begin
            res_mem[res_wr_idx_s] <= pixel_s;
        end
    end

    // Registered result read; same-cycle collision naturally returns old data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_r <= {DATA_WIDTH{1'b0}};
        end else if ((32'(bus.result_rd_ch) < 32'(CHANNEL_NUM)) &&
                     (32'(bus.result_rd_addr) < 32'(OUT_PIX))) begin
            result_r <= res_mem[res_rd_idx_s];
        end else begin
            result_r <= {DATA_WIDTH{1'b0}};
        end
    end

    conv_mac_unit #(
        .DATA_WIDTH     (DATA_WIDTH),
        .FRACTION_WIDTH (FRACTION_WIDTH),
        .ACC_WIDTH      (ACC_WIDTH)
    ) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear  (acc_clear_s),
        .en     (tap_valid_r),
        .data   (bus.conv_data),
        .weight (wt_q_r),
        .bias   (bias_mem[ch_r]),
        .pixel  (pixel_s)
    );

    assign bus.conv_data_addr = addr_r;
    assign bus.result         = result_r;
    assign bus.channel_count  = ch_r;
    assign bus.busy           = busy_r;
    assign bus.done           = done_r;

endmodule
